axi4_burst_addr_gen: RTL

Parametrised AXI4 burst beat generator for the master and slave BFMs. Accepts one burst command (start address, AxLEN, AxSIZE, AxBURST), validates it against AXI4 rules, then emits one beat per handshake with per-beat address, byte-lane strobe, beat index and last flag for FIXED, INCR and WRAP bursts. It sits between the transaction-to-pin conversion logic and the W/R data channel drivers, and replaces per-driver address arithmetic with a single width-generic block.

---
 rtl/axi4_burst_addr_gen_if.sv | 37 +++
 rtl/axi4_burst_addr_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axi4_burst_addr_gen_if.sv
// Command/beat/error bundle for axi4_burst_addr_gen.
// master: command source and beat consumer. slave: the generator.
interface axi4_burst_addr_gen_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [7:0]               cmd_len;
    logic [2:0]               cmd_size;
    logic [1:0]               cmd_burst;

    logic                     beat_valid;
    logic                     beat_ready;
    logic [ADDRESS_WIDTH-1:0] beat_addr;
    logic [NB-1:0]            beat_strb;
    logic [7:0]               beat_index;
    logic                     beat_last;

    logic                     err_valid;
    logic [2:0]               err_code;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_index, beat_last,
               err_valid, err_code
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_strb, beat_index, beat_last,
               err_valid, err_code
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst beat generator: validates one command, then emits per-beat
// address, byte strobe, index and last flag for FIXED/INCR/WRAP bursts.
// Optional feature macro: AXI4_BURST_4KB_CHECK_EN (reject INCR bursts
// crossing a 4KB boundary with err_code 5).
module axi4_burst_addr_gen #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi4_burst_addr_gen_if.slave  bus
);
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [7:0]      len_q;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic [AW-1:0]   wrap_mask_q;

    logic            accept_c;
    logic [2:0]      err_c;
    logic [31:0]     req_bytes_c;
    logic [AW-1:0]   step_c;
    logic [AW-1:0]   next_addr_c;

    // Active lanes from the address lane up to the end of its size-aligned slot.
    function automatic logic [NB-1:0] lane_strb(input logic [AW-1:0] addr,
                                                input logic [2:0]    size);
        int unsigned bytes;
        int unsigned lo;
        int unsigned hi;
        logic [NB-1:0] strb;
        bytes = 32'd1 << size;
        lo    = 32'(addr[LW-1:0]) % NB;
        hi    = (lo & ~(bytes - 32'd1)) + bytes - 32'd1;
        strb  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            strb[i] = (i >= lo) && (i <= hi);
        end
        return strb;
    endfunction

    assign accept_c = bus.cmd_valid && bus.cmd_ready;

`ifdef AXI4_BURST_4KB_CHECK_EN
    // One past the last byte of an INCR burst, relative to its 4KB page.
    // WRAP spans are power-of-two aligned and at most 2KB, so they never cross.
    logic [16:0] incr_end_c;
    assign incr_end_c = 17'(bus.cmd_addr[11:0] & ~12'(req_bytes_c - 32'd1))
                      + ((17'(bus.cmd_len) + 17'd1) << bus.cmd_size);
`endif

    // Command legality check, lowest code wins.
    always_comb begin
        req_bytes_c = 32'd1 << bus.cmd_size;
        err_c       = 3'd0;
        if (bus.cmd_burst == BURST_RSVD) begin
            err_c = 3'd1;
        end else if (req_bytes_c > NB) begin
            err_c = 3'd2;
        end else if (bus.cmd_burst == BURST_WRAP &&
                     !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            err_c = 3'd3;
        end else if (bus.cmd_burst == BURST_WRAP &&
                     ((32'(bus.cmd_addr[6:0]) & (req_bytes_c - 32'd1)) != 32'd0)) begin
            err_c = 3'd4;
        end
`ifdef AXI4_BURST_4KB_CHECK_EN
        else if (bus.cmd_burst == BURST_INCR && incr_end_c > 17'd4096) begin
            err_c = 3'd5;
        end
`endif
    end

    // Address of the following beat; WRAP keeps the high part and wraps the low part.
    always_comb begin
        step_c      = AW'(1) << size_q;
        next_addr_c = bus.beat_addr;
        case (burst_q)
            BURST_INCR:  next_addr_c = (bus.beat_addr & ~(step_c - AW'(1))) + step_c;
            BURST_WRAP:  next_addr_c = (bus.beat_addr & ~wrap_mask_q)
                                     | ((bus.beat_addr + step_c) & wrap_mask_q);
            default:     next_addr_c = bus.beat_addr;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= BURST_FIXED;
            wrap_mask_q    <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.beat_valid <= 1'b0;
            bus.beat_addr  <= '0;
            bus.beat_strb  <= '0;
            bus.beat_index <= '0;
            bus.beat_last  <= 1'b0;
            bus.err_valid  <= 1'b0;
            bus.err_code   <= 3'd0;
        end else begin
            bus.err_valid <= 1'b0;
            bus.err_code  <= 3'd0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (accept_c) begin
                        if (err_c != 3'd0) begin
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= err_c;
                        end else begin
                            state          <= BURST;
                            len_q          <= bus.cmd_len;
                            size_q         <= bus.cmd_size;
                            burst_q        <= bus.cmd_burst;
                            wrap_mask_q    <= AW'(((32'(bus.cmd_len) + 32'd1) << bus.cmd_size) - 32'd1);
                            bus.cmd_ready  <= 1'b0;
                            bus.beat_valid <= 1'b1;
                            bus.beat_addr  <= bus.cmd_addr;
                            bus.beat_strb  <= lane_strb(bus.cmd_addr, bus.cmd_size);
                            bus.beat_index <= 8'd0;
                            bus.beat_last  <= (bus.cmd_len == 8'd0);
                        end
                    end
                end
                BURST: begin
                    if (bus.beat_ready) begin
                        if (bus.beat_last) begin
                            state          <= IDLE;
                            bus.beat_valid <= 1'b0;
                            bus.cmd_ready  <= 1'b1;
                        end else begin
                            bus.beat_addr  <= next_addr_c;
                            bus.beat_strb  <= lane_strb(next_addr_c, size_q);
                            bus.beat_index <= bus.beat_index + 8'd1;
                            bus.beat_last  <= ((bus.beat_index + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
